pipe_stage_skid: RTL

//   Generic parametrised pipeline register between two datapath stages.

---
 rtl/pipe_stage_skid_pkg.sv | 19 +
 rtl/pipe_stage_skid_slot.sv | 30 +++
 rtl/pipe_stage_skid.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: bubble fill value, per-stage payload widths and
// the {main_v, skid_v} occupancy encoding.
package pipe_stage_skid_pkg;

   localparam logic BUBBLE_ZERO = 1'b0;

   localparam int PIPE_IF_ID_W  = 96;   // Instr + PC + PCPlus4
   localparam int PIPE_ID_EX_W  = 160;
   localparam int PIPE_EX_MEM_W = 105;
   localparam int PIPE_MEM_WB_W = 104;

   // {main_v, skid_v}; 2'b01 cannot occur because the skid only fills behind main.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } slot_state_e;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// Single payload entry: valid bit plus data, clear has priority over load and
// returns the data to the bubble value.
module pipe_slot
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = PIPE_IF_ID_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic              valid,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= {DATA_W{BUBBLE_ZERO}};
      end else if (clear) begin
         valid <= 1'b0;
         q     <= {DATA_W{BUBBLE_ZERO}};
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with optional 2-entry skid so in_ready can be
// a flop; flush turns every held entry into a bubble.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = PIPE_IF_ID_W,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              push, pop;
   logic              main_v, skid_v;
   logic              main_load, main_clear;
   logic [DATA_W-1:0] main_d, main_q, skid_q;

   assign push = in_valid & in_ready;
   assign pop  = main_v & out_ready;

   generate
      if (SKID) begin : g_skid
         logic skid_load, skid_clear;

         assign in_ready = ~skid_v;

         // Skid drains into main before any new word, which keeps order intact.
         always_comb begin
            main_load = 1'b0;
            main_d    = in_data;
            skid_load = 1'b0;
            if (!main_v) begin
               main_load = push;
            end else if (pop) begin
               if (skid_v) begin
                  main_load = 1'b1;
                  main_d    = skid_q;
               end else begin
                  main_load = push;
               end
            end else begin
               skid_load = push;
            end
         end

         assign skid_clear = flush | (pop & skid_v);

         pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clk   (clk),
            .rst   (reset),
            .clear (skid_clear),
            .load  (skid_load),
            .d     (in_data),
            .valid (skid_v),
            .q     (skid_q)
         );
      end else begin : g_noskid
         assign in_ready  = out_ready | ~main_v;
         assign main_load = push;
         assign main_d    = in_data;
         assign skid_v    = 1'b0;
         assign skid_q    = {DATA_W{BUBBLE_ZERO}};
      end
   endgenerate

   assign main_clear = flush | (pop & ~main_load);

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk   (clk),
      .rst   (reset),
      .clear (main_clear),
      .load  (main_load),
      .d     (main_d),
      .valid (main_v),
      .q     (main_q)
   );

   assign out_valid = main_v;
   assign out_data  = main_q;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   assert property (@(posedge clk) disable iff (reset)
      ({main_v, skid_v} != 2'b01));

endmodule
